seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for the board's four-digit, common-anode 7-segment display. It is the output-side counterpart of the button/switch debouncer: the debouncer conditions operator inputs into the core, and this block carries core values back out to the operator. Display data is loaded through a one-cycle strobe into a shadow register and committed only at frame boundaries, so a digit scan never shows torn data. Each digit also has its own decimal point, blank, and blink control.

## Interface
- SCAN_DIV, 100000: clock cycles each digit is driven (1 ms at 100 MHz); legal range ≥2.
- BLINK_FRAMES, 125: full frames per blink half-period; legal range ≥1.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- load  input  1  one-cycle strobe; captures data/point/blank/blink into the shadow register.
- data  input  16  four hex nibbles; data[3:0] is digit 0 (rightmost).
- point  input  4  per-digit decimal point on (1 = lit).
- blank  input  4  per-digit blank (1 = digit dark).
- blink  input  4  per-digit blink enable.
- AN  output  4  digit anodes, active-low; AN[0] is digit 0.
- SEGMENT  output  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.
- frame_tick  output  1  one-cycle pulse at each frame boundary.
- upd_ack  output  1  one-cycle pulse when pending shadow data is committed.

## Operation
- Scan divider `div` counts 0..SCAN_DIV-1. On the terminal count, `div` returns to 0 and digit index `idx` advances 0→1→2→3→0.
- Boundary cycle B is the cycle where `div==SCAN_DIV-1` and `idx==3`. At the clock edge ending B:
  - active ← shadow if `pending`.
  - `pending` ← 0.
  - upd_ack ← old `pending`.
  - frame_tick ← 1.
  - Both pulses deassert on the next cycle.
- Load behaviour:
  - load=1 writes the shadow register and sets `pending`.
  - A repeat load while pending overwrites the shadow; latest wins and only one upd_ack is issued.
  - A load during B: the edge ending B commits the old shadow. The new values land in the shadow, `pending` stays 1, and they are committed at the next boundary.
- Blink:
  - The frame counter counts boundaries 0..BLINK_FRAMES-1. On wrap, `phase` toggles.
  - While `phase==1`, a digit with active blink=1 is treated as blanked.
- Per-digit output, from `idx` and the active registers:
  - Blanked digit: AN bit stays 1 and SEGMENT=8'hFF.
  - Otherwise: AN=~(1<<idx); SEGMENT={~point[idx], hex7(nibble)}.
- hex7 decoding (g..a, active-low):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Reset values:
  - AN=4'b1111, SEGMENT=8'hFF, frame_tick=0, upd_ack=0.
  - div=0, idx=0, frame counter=0, phase=0, pending=0.
  - shadow and active data/point/blink = 0; shadow and active blank = 4'b1111. The display is dark until the first committed load.

## Timing
- AN and SEGMENT are registered and lag `idx`/active state by exactly one clock. No combinational path exists from the inputs to AN or SEGMENT.
- Each digit is driven for exactly SCAN_DIV cycles; a frame is 4·SCAN_DIV cycles.
- Load-to-display latency is 2 to 4·SCAN_DIV+1 cycles, depending on frame position.
- upd_ack asserts in the first cycle of the new frame; the new data appears on AN/SEGMENT one cycle later.
- Blink half-period is BLINK_FRAMES·4·SCAN_DIV cycles.
- Reset asserted mid-frame immediately forces all reset values, asynchronously, and discards any pending load. Scanning resumes at digit 0 on the first edge after release.
- No output glitches at digit changes: only one AN bit is low in any cycle.

## Test plan
Run with SCAN_DIV=4, BLINK_FRAMES=2.
1. Reset, then 20 idle cycles → AN=1111, SEGMENT=FF throughout; frame_tick pulses every 16 cycles.
2. Load data=16'h1234, point=0, blank=0, blink=0 → one upd_ack at the next boundary. Following frame shows:
   - AN=1110 with SEGMENT=99 (digit "4"), then
   - AN=1101 with B0, then
   - AN=1011 with A4, then
   - AN=0111 with F9, each for 4 cycles.
3. Load 16'hAAAA, then 16'h8F0C two cycles later, within the same frame → single upd_ack; the displayed digits are C6, C0, 8E, 80 (digit 0 to 3).
4. Load during the boundary cycle B → no upd_ack for it at that edge; exactly one upd_ack at the following boundary; new data appears only in the second frame.
5. blink=4'b0001, point=4'b0001, data=16'h0000 → digit 0 shows SEGMENT=40 for 2 frames, then AN stays 1111 during digit 0's slot for 2 frames, repeating. Digits 1–3 show C0 continuously.
6. Assert rst mid-digit-2 with a load pending → AN=1111 and SEGMENT=FF immediately. After release, no upd_ack appears and the display remains dark.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Host-side load bus for the 7-segment scan driver: shadow-register write
// strobe with per-digit data/controls, and the commit acknowledge back.
interface seg7_scan_driver_if;
  logic        load;
  logic [15:0] data;
  logic [3:0]  point;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic        upd_ack;

  modport master (output load, data, point, blank, blink, input upd_ack);
  modport slave  (input load, data, point, blank, blink, output upd_ack);
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner with a frame-synchronous shadow
// register, per-digit decimal point, blank and blink.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   host,
  output logic [3:0]          an_o,
  output logic [7:0]          segment_o,
  output logic                frame_tick_o
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  logic          pending_q, pending_d;
  logic [15:0]   sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [3:0]    sh_point_q, sh_point_d, act_point_q, act_point_d;
  logic [3:0]    sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [3:0]    sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_tick_q, frame_tick_d;
  logic          upd_ack_q, upd_ack_d;
  logic          boundary;
  logic [3:0]    dark;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // A digit is dark when blanked, or when blinking during the off phase.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dark
      assign dark[gi] = act_blank_q[gi] | (act_blink_q[gi] & phase_q);
    end
  endgenerate

  assign boundary = (div_q == DIV_LAST) && (idx_q == 2'd3);
  assign nib      = act_data_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    div_d        = div_q + 1'b1;
    idx_d        = idx_q;
    frm_d        = frm_q;
    phase_d      = phase_q;
    sh_data_d    = sh_data_q;
    sh_point_d   = sh_point_q;
    sh_blank_d   = sh_blank_q;
    sh_blink_d   = sh_blink_q;
    act_data_d   = act_data_q;
    act_point_d  = act_point_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    pending_d    = pending_q;
    frame_tick_d = boundary;
    upd_ack_d    = boundary & pending_q;
    an_d         = 4'b1111;
    seg_d        = 8'hFF;

    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // Commit uses the pre-edge shadow, so a load in the boundary cycle
    // lands in the shadow and waits for the next frame.
    if (boundary) begin
      pending_d = 1'b0;
      if (pending_q) begin
        act_data_d  = sh_data_q;
        act_point_d = sh_point_q;
        act_blank_d = sh_blank_q;
        act_blink_d = sh_blink_q;
      end
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    if (host.load) begin
      sh_data_d  = host.data;
      sh_point_d = host.point;
      sh_blank_d = host.blank;
      sh_blink_d = host.blink;
      pending_d  = 1'b1;
    end

    if (!dark[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = {~act_point_q[idx_q], hex7(nib)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b0;
      pending_q    <= 1'b0;
      sh_data_q    <= '0;
      sh_point_q   <= '0;
      sh_blank_q   <= 4'b1111;
      sh_blink_q   <= '0;
      act_data_q   <= '0;
      act_point_q  <= '0;
      act_blank_q  <= 4'b1111;
      act_blink_q  <= '0;
      an_q         <= 4'b1111;
      seg_q        <= 8'hFF;
      frame_tick_q <= 1'b0;
      upd_ack_q    <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      pending_q    <= pending_d;
      sh_data_q    <= sh_data_d;
      sh_point_q   <= sh_point_d;
      sh_blank_q   <= sh_blank_d;
      sh_blink_q   <= sh_blink_d;
      act_data_q   <= act_data_d;
      act_point_q  <= act_point_d;
      act_blank_q  <= act_blank_d;
      act_blink_q  <= act_blink_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
      upd_ack_q    <= upd_ack_d;
    end
  end

  assign an_o         = an_q;
  assign segment_o    = seg_q;
  assign frame_tick_o = frame_tick_q;
  assign host.upd_ack = upd_ack_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed and random loads compared cycle by
// cycle against a time-based model of the expected display.
module tb_seg7_scan_driver;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] an_o;
  logic [7:0] segment_o;
  logic       frame_tick_o;

  seg7_scan_driver_if bus_if ();

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (bus_if),
    .an_o         (an_o),
    .segment_o    (segment_o),
    .frame_tick_o (frame_tick_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  b;
    logic [3:0]  k;
  } ld_t;

  ld_t lq[$];
  int  cyc;
  int  n_checks = 0;
  int  n_err = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Cycle c is counted from reset release; outputs in cycle c show the
  // digit scanned in cycle c-1. Frame k displays the newest load made at
  // least two cycles before the frame starts.
  function automatic void expect_at(input int c, output logic [3:0] an, output logic [7:0] seg,
                                    output logic ft, output logic ack);
    int pc, k, idx, ph;
    logic [15:0] d;
    logic [3:0] p, b, bl;
    an = 4'hF; seg = 8'hFF; ft = 1'b0; ack = 1'b0;
    if (c == 0) return;
    pc = c - 1;
    k = pc / FR;
    idx = (pc / SD) % 4;
    ph = (k / BF) % 2;
    d = 16'h0; p = 4'h0; b = 4'hF; bl = 4'h0;
    foreach (lq[i]) begin
      if (lq[i].cyc <= FR * k - 2) begin
        d = lq[i].d; p = lq[i].p; b = lq[i].b; bl = lq[i].k;
      end
    end
    if (!(b[idx] || (bl[idx] && ph == 1))) begin
      an = 4'hF;
      an[idx] = 1'b0;
      seg = {~p[idx], hex_tbl[d[idx*4 +: 4]]};
    end
    if (c % FR == 0) begin
      ft = 1'b1;
      foreach (lq[i])
        if (lq[i].cyc >= c - FR - 1 && lq[i].cyc <= c - 2) ack = 1'b1;
    end
  endfunction

  task automatic check_cycle();
    logic [3:0] ean;
    logic [7:0] eseg;
    logic eft, eack;
    expect_at(cyc, ean, eseg, eft, eack);
    check("an", 32'(an_o), 32'(ean));
    check("segment", 32'(segment_o), 32'(eseg));
    check("frame_tick", 32'(frame_tick_o), 32'(eft));
    check("upd_ack", 32'(bus_if.upd_ack), 32'(eack));
  endtask

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p,
                      input logic [3:0] b, input logic [3:0] k);
    bus_if.load = ld;
    bus_if.data = d;
    bus_if.point = p;
    bus_if.blank = b;
    bus_if.blink = k;
    if (ld) begin
      lq.push_back('{cyc, d, p, b, k});
      $display("load cyc=%0d pos=%0d data=%h point=%b blank=%b blink=%b", cyc, cyc % FR, d, p, b, k);
    end
    @(posedge clk);
    #1;
    cyc++;
    bus_if.load = 1'b0;
    check_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic align(input int pos);
    while (cyc % FR != pos) step(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    bus_if.load = 1'b0;
    bus_if.data = '0;
    bus_if.point = '0;
    bus_if.blank = '0;
    bus_if.blink = '0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_cycle();

    idle(20);
    step(1'b1, 16'h1234, 4'h0, 4'h0, 4'h0);
    idle(40);

    align(1);
    step(1'b1, 16'hAAAA, 4'h0, 4'h0, 4'h0);
    idle(1);
    step(1'b1, 16'h8F0C, 4'h0, 4'h0, 4'h0);
    idle(40);

    align(FR - 1);
    step(1'b1, 16'h5A6B, 4'b0110, 4'h0, 4'h0);
    idle(40);

    step(1'b1, 16'h0000, 4'b0001, 4'h0, 4'b0001);
    idle(8 * FR);

    repeat (300) begin
      if ($urandom_range(0, 5) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom), 4'($urandom));
      else
        idle(1);
    end

    // Reset mid-digit-2 with a load pending must blank immediately and drop the load.
    align(2 * SD);
    step(1'b1, 16'h7777, 4'hF, 4'h0, 4'h0);
    rst = 1'b1;
    #1;
    check("rst_an", 32'(an_o), 32'h0000000F);
    check("rst_segment", 32'(segment_o), 32'h000000FF);
    check("rst_upd_ack", 32'(bus_if.upd_ack), 32'h0);
    check("rst_frame_tick", 32'(frame_tick_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lq.delete();
    cyc = 0;
    check_cycle();
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
